// File: rtl/delta_lif_neuron.sv
// Leaky integrate-and-fire neuron with a refractory period and send-on-delta
// event encoding of the membrane potential. One integration step is taken per
// clock with en=1. All outputs are registered and appear one cycle after the step.
//
// state (membrane u) | meaning
// ------------------ | ---------------------------------------------
// cnt == 0           | integrating: u <- sat(u - leak + cur_in)
// cnt != 0           | refractory: u <- u - leak, cur_in ignored
module delta_lif_neuron #(
   parameter int W          = 8,
   parameter int BETA_SHIFT = 1,
   parameter int V_TH       = 200,
   parameter int DELTA_TH   = 10,
   parameter int REFRAC     = 4,
   parameter int SUB_RESET  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] cur_in,
   output logic [W-1:0] state,
   output logic         fire,
   output logic         delta_valid,
   output logic         delta_sign,
   output logic [W-1:0] delta_mag,
   output logic         refrac_active
);

   localparam int CW = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;
   localparam logic [W:0]    VTH_EXT = (W+1)'(V_TH);
   localparam logic [W:0]    DTH_EXT = (W+1)'(DELTA_TH);
   localparam logic [W-1:0]  VTH_W   = W'(V_TH);
   localparam logic [CW-1:0] REFRAC_LOAD = CW'(REFRAC);

   logic [W-1:0]  ref_q;
   logic [CW-1:0] cnt;

   logic [W-1:0]  leak;
   logic [W-1:0]  decayed;
   logic [W:0]    sum;
   logic [W-1:0]  sum_sat;
   logic [W-1:0]  u_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          fire_nxt;
   logic [W:0]    d;
   logic          d_neg;
   logic [W:0]    d_abs;
   logic          d_hit;

   // Next membrane value, refractory count and delta event for a step taken now.
   always_comb begin
      leak     = state >> BETA_SHIFT;
      decayed  = state - leak;
      sum      = {1'b0, decayed} + {1'b0, cur_in};
      sum_sat  = sum[W] ? {W{1'b1}} : sum[W-1:0];
      fire_nxt = 1'b0;
      u_nxt    = decayed;
      cnt_nxt  = cnt;
      if (cnt != '0) begin
         cnt_nxt = cnt - 1'b1;
      end else if ({1'b0, sum_sat} >= VTH_EXT) begin
         fire_nxt = 1'b1;
         u_nxt    = (SUB_RESET != 0) ? (sum_sat - VTH_W) : '0;
         cnt_nxt  = REFRAC_LOAD;
      end else begin
         u_nxt = sum_sat;
      end
      // Both operands are unsigned W bits, so W+1 bits hold the signed difference
      // and its magnitude always fits back into W bits.
      d     = {1'b0, u_nxt} - {1'b0, ref_q};
      d_neg = d[W];
      d_abs = d_neg ? (~d + 1'b1) : d;
      d_hit = (d_abs >= DTH_EXT);
   end

   // Commit a step on en; event pulses drop when idle, delta fields hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= '0;
         ref_q         <= '0;
         cnt           <= '0;
         fire          <= 1'b0;
         delta_valid   <= 1'b0;
         delta_sign    <= 1'b0;
         delta_mag     <= '0;
         refrac_active <= 1'b0;
      end else if (en) begin
         state         <= u_nxt;
         cnt           <= cnt_nxt;
         refrac_active <= (cnt_nxt != '0);
         fire          <= fire_nxt;
         delta_valid   <= d_hit;
         if (d_hit) begin
            delta_sign <= d_neg;
            delta_mag  <= d_abs[W-1:0];
            ref_q      <= u_nxt;
         end
      end else begin
         fire        <= 1'b0;
         delta_valid <= 1'b0;
      end
   end

endmodule
